uart_alu_ctrl: RTL
==================

// Module: uart_alu_ctrl
// PURPOSE
//  Packet sequencer between uart_rx (AXI-stream in) and uart_tx (AXI-stream out) of the UART ALU.
//  Parses host packets [opcode][rsvd][len_lo][len_hi][payload], runs ECHO or 32-bit ADD-reduce,
//  streams result bytes back to uart_tx. Single owner of both UART stream interfaces.
// PARAMETERS
//  DATA_WIDTH      8        stream byte width; only 8 supported
//  OP_ECHO         8'hEC    opcode: return payload unchanged
//  OP_ADD          8'hA0    opcode: sum of 32-bit LE operands, modulo 2^32
//  TIMEOUT_CYCLES  1200000  inter-byte timeout in clk_i cycles (100 ms @ 12 MHz); used only with macro
// PORTS
//  clk_i          in   1   single clock; all logic rising-edge
//  reset_i        in   1   asynchronous, active-low reset
//  s_axis_tdata   in   8   byte from uart_rx
//  s_axis_tvalid  in   1   rx byte valid
//  s_axis_tready  out  1   controller accepts rx byte
//  m_axis_tdata   out  8   byte to uart_tx
//  m_axis_tvalid  out  1   tx byte valid
//  m_axis_tready  in   1   uart_tx accepts byte
//  busy_o         out  1   high whenever state != IDLE
//  err_opcode_o   out  1   1-cycle pulse: unknown opcode
//  err_len_o      out  1   1-cycle pulse: illegal length
//  err_timeout_o  out  1   1-cycle pulse: inter-byte timeout (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, all err_*=0, acc=0.
//  Byte transfer = tvalid&tready same edge. len = {len_hi,len_lo}, total packet bytes incl. 4-byte header.
//  FSM:
//   IDLE    tready=1; take byte -> latch opcode -> RSVD
//   RSVD    tready=1; discard byte -> LEN_LO -> LEN_HI (tready=1 in each)
//   LEN_HI  on accept, rem=len-4, then decide:
//           len<4                          -> err_len_o pulse, IDLE
//           opcode unknown                 -> err_opcode_o pulse, DRAIN (IDLE if rem=0)
//           ECHO                           -> ECHO (IDLE if rem=0, no tx output)
//           ADD, rem=0 or rem[1:0]!=0      -> err_len_o pulse, DRAIN
//           ADD otherwise                  -> acc=0, ADD_RX
//   ECHO    combinational pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready;
//           rem-- per transfer; rem reaches 0 -> IDLE
//   ADD_RX  tready=1; shift byte into 32-bit operand register LSB-first; every 4th byte
//           acc<=acc+operand (carry discarded) same edge; rem-- ; rem=0 -> SEND, idx=0
//   SEND    tready=0; m_tvalid=1, m_tdata=acc[8*idx+:8] (LSB first); tdata held stable while
//           tvalid&!tready; idx++ per transfer; after idx=3 accepted -> IDLE
//   DRAIN   tready=1; discard rem bytes; rem=0 -> IDLE
//  Latency: first SEND byte valid the cycle after final operand byte accepted; ECHO zero-cycle.
//  err_* pulses asserted in the cycle after LEN_HI accept; never overlap.
//  rem is 16-bit; len=0xFFFF legal (rem=0xFFFB); no wrap since len>=4 checked first.
//  s_axis_tready never high in SEND; m_axis_tvalid never high outside ECHO/SEND.
//  Reset mid-packet: immediate IDLE; partially sent bytes abandoned; host resynchronises.
// CONFIGURATION
//  UART_ALU_CTRL_TIMEOUT_EN defined: counter clears on every rx transfer and in IDLE/SEND; counts
//   in RSVD/LEN_LO/LEN_HI/ECHO/ADD_RX/DRAIN; on reaching TIMEOUT_CYCLES -> err_timeout_o pulse, IDLE,
//   acc cleared, no tx output. ECHO bytes already forwarded stay forwarded.
//  Not defined: no counter logic, err_timeout_o=0, FSM waits indefinitely for bytes.
// TESTING
//  1 ECHO: rx EC 00 06 00 41 42 -> tx 41 42; busy_o low after 42 passes; no err pulse.
//  2 ADD: rx A0 00 0C 00 01 00 00 00 02 00 00 00 -> tx 03 00 00 00.
//  3 ADD wrap: operands FF FF FF FF + 01 00 00 00 -> tx 00 00 00 00; len 0x0005 -> err_len_o, 1 byte drained, no tx.
//  4 Bad opcode: rx 55 00 06 00 AA BB -> err_opcode_o once, AA BB drained, no tx; next packet 2 decodes correctly.
//  5 Backpressure/reset: hold m_axis_tready=0 3 cycles mid-SEND -> tdata stable; reset_i low mid-ADD_RX -> all outputs reset values, next packet OK.
//  6 Macro on, TIMEOUT_CYCLES=100: stop after A0 00 08 00 01 -> err_timeout_o at cycle 100, IDLE, no tx.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between uart_rx and uart_tx: parses [op][rsvd][len_lo][len_hi][payload],
// runs ECHO or 32-bit ADD-reduce. Optional inter-byte timeout via UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [7:0]  OP_ECHO    = 8'hEC,
  parameter logic [7:0]  OP_ADD     = 8'hA0
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 1200000
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  err_opcode_o,
  output logic                  err_len_o,
  output logic                  err_timeout_o
);

  typedef enum logic [2:0] {
    IDLE, RSVD, LEN_LO, LEN_HI, ECHO, ADD_RX, SEND, DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] opnd_q, opnd_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        err_op_q, err_op_d;
  logic        err_len_q, err_len_d;
  // Keeps tready low while reset is asserted even though the state is IDLE.
  logic        run_q;

  logic        rx_fire, tx_fire;
  logic [15:0] len, len_rem, rem_dec;
  logic        tmo_hit;

  assign rx_fire = s_axis_tvalid & s_axis_tready;
  assign tx_fire = m_axis_tvalid & m_axis_tready;
  assign len     = {s_axis_tdata, len_lo_q};
  assign len_rem = len - 16'd4;
  assign rem_dec = rem_q - 16'd1;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_tmo_q;
  logic             tmo_count;

  assign tmo_count = (state_q != IDLE) && (state_q != SEND);
  assign tmo_hit   = tmo_count && !rx_fire && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (!tmo_count || rx_fire || tmo_hit) tmo_d = '0;
    else                                  tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= tmo_hit;
    end
  end

  assign err_timeout_o = err_tmo_q;
`else
  assign tmo_hit       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    len_lo_d      = len_lo_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    opnd_d        = opnd_q;
    bcnt_d        = bcnt_q;
    idx_d         = idx_q;
    err_op_d      = 1'b0;
    err_len_d     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    case (state_q)
      IDLE: begin
        s_axis_tready = run_q;
        if (rx_fire) begin
          opcode_d = s_axis_tdata;
          state_d  = RSVD;
        end
      end
      RSVD: begin
        s_axis_tready = 1'b1;
        if (rx_fire) state_d = LEN_LO;
      end
      LEN_LO: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          len_lo_d = s_axis_tdata;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          rem_d = len_rem;
          if (len < 16'd4) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else if (opcode_q != OP_ECHO && opcode_q != OP_ADD) begin
            err_op_d = 1'b1;
            state_d  = (len_rem == 16'd0) ? IDLE : DRAIN;
          end else if (opcode_q == OP_ECHO) begin
            state_d = (len_rem == 16'd0) ? IDLE : ECHO;
          end else if (len_rem == 16'd0 || len_rem[1:0] != 2'd0) begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            acc_d   = '0;
            bcnt_d  = '0;
            state_d = ADD_RX;
          end
        end
      end
      ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (rx_fire) begin
          rem_d = rem_dec;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      ADD_RX: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          opnd_d = {s_axis_tdata, opnd_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) acc_d = acc_q + {s_axis_tdata, opnd_q};
          rem_d = rem_dec;
          if (rem_q == 16'd1) begin
            idx_d   = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = acc_q[8*idx_q +: 8];
        if (tx_fire) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      DRAIN: begin
        // Zero-length drain (ADD with len=4) exits without consuming a byte.
        s_axis_tready = (rem_q != 16'd0);
        if (rem_q == 16'd0) state_d = IDLE;
        else if (rx_fire) begin
          rem_d = rem_dec;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d = IDLE;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      len_lo_q  <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      bcnt_q    <= '0;
      idx_q     <= '0;
      err_op_q  <= 1'b0;
      err_len_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      len_lo_q  <= len_lo_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      bcnt_q    <= bcnt_d;
      idx_q     <= idx_d;
      err_op_q  <= err_op_d;
      err_len_q <= err_len_d;
      run_q     <= 1'b1;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign err_opcode_o = err_op_q;
  assign err_len_o    = err_len_q;

endmodule
